// File: rtl/fifo_rtl_pkg.sv
// Shared types and defaults for the FIFO read-side stream logic.
package fifo_rtl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Output buffer occupancy (head/skid register pair).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Number of words held in the buffer for a given occupancy state.
  function automatic logic [1:0] occ_words(input occ_t occ);
    logic [1:0] n;
    case (occ)
      OCC_ONE: n = 2'd1;
      OCC_TWO: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/skid buffer that soaks up the FIFO's one-cycle read latency.
// Stream handshake: a word transfers on a rising edge where valid_o && ready_i;
// valid_o never drops and data_o never changes while valid_o && !ready_i.
module fifo_skid_buf
  import fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_t                  occ_o
);

  occ_t                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid_q;
  logic                  fire;

  assign fire    = valid_q && ready_i;
  assign valid_o = valid_q;
  assign data_o  = head_q;
  assign occ_o   = occ_q;

  // Occupancy FSM and head/skid steering; the head always holds the oldest word.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (wr_i) begin
          occ_d  = OCC_ONE;
          head_d = wr_data_i;
        end
      end
      OCC_ONE: begin
        if (wr_i) begin
          if (fire) begin
            head_d = wr_data_i;
          end else begin
            skid_d = wr_data_i;
            occ_d  = OCC_TWO;
          end
        end else if (fire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // A write without a fire cannot happen here: the credit check upstream
        // never lets buffer plus in-flight exceed two words.
        if (fire) begin
          head_d = skid_q;
          if (wr_i) begin
            skid_d = wr_data_i;
          end else begin
            occ_d = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // State and data registers; valid is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= (occ_d != OCC_EMPTY);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from the synchronous FIFO and streams them out in order.
// Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
// m_valid holds and m_data stays stable until the word is accepted.
module fifo_stream_reader
  import fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic                 fire;
  logic [2:0]           credit_sum;
  occ_t                 occ;

  assign fire = m_valid && m_ready;

  // Words that will be held after this edge: buffered + arriving - leaving.
  // fire implies at least one buffered word, so this cannot underflow.
  assign credit_sum = {1'b0, occ_words(occ)} + {2'b00, inflight_q} - {2'b00, fire};

  // Pop only when the result will still fit in the two-entry buffer.
  assign fifo_rd_en = rd_enable && !fifo_empty && !rst && (credit_sum < 3'd2);

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (inflight_q),
    .wr_data_i(fifo_rd_data),
    .ready_i  (m_ready),
    .valid_o  (m_valid),
    .data_o   (m_data),
    .occ_o    (occ)
  );

  // Next-state for the in-flight flag and delivered-word counter.
  always_comb begin
    inflight_d  = fifo_rd_en;
    pop_count_d = pop_count_q;
    if (fire) begin
      pop_count_d = pop_count_q + 1'b1;
    end
  end

  // In-flight flag and delivered-word counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
    end
  end

  assign pop_count = pop_count_q;

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO. It pops words from the FIFO read port and presents them in order on a valid/ready stream. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so the stream runs at one word per cycle with no bubbles while the consumer is ready. It sits between the FIFO and any downstream consumer and shares the FIFO's clock and reset.

## Interface
Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `DATA_WIDTH`, 8: FIFO word and stream data width.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset; must be the same reset that drives the FIFO.
- `rd_enable` in 1: allows new FIFO pops; when low, the buffer still drains.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop strobe (combinational).
- `fifo_rd_data` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `m_valid` out 1: stream data valid (registered).
- `m_data` out DATA_WIDTH: stream data (registered).
- `m_ready` in 1: consumer accepts.
- `pop_count` out CNT_WIDTH: number of words delivered (`m_valid && m_ready`), wraps.

## Operation
- State:
  - `occ` ∈ {OCC_EMPTY, OCC_ONE, OCC_TWO}: buffer occupancy.
  - `inflight`: 1-bit registered copy of `fifo_rd_en`.
  - Head register, which drives `m_data`, and a skid register.
- `fire = m_valid && m_ready`.
- `fifo_rd_en = rd_enable && !fifo_empty && !rst && (occ + inflight - fire) < 2`.
  - This is combinational from `m_ready`; the path is accepted.
- When `inflight` = 1, `fifo_rd_data` is written into the buffer that cycle:
  - Into the head if the head is empty or is being consumed while the skid is empty.
  - Otherwise into the skid.
- On `fire` with the skid full, the skid moves into the head. Order is strictly FIFO.
- Occupancy transitions (w = inflight write, f = fire):
  - EMPTY: w → ONE.
  - ONE: w&!f → TWO; !w&f → EMPTY; otherwise stays ONE.
  - TWO: f&!w → ONE; otherwise stays TWO.
  - TWO with w&!f cannot occur; the credit rule above guarantees it.
- `m_valid = (occ != OCC_EMPTY)`.
- `m_data` is held stable while `m_valid && !m_ready`.
- `pop_count` increments by 1 on each `fire` and wraps modulo 2^CNT_WIDTH.
- `rd_enable` deasserted: no new pops. An in-flight word is still captured, and the buffer drains normally.
- FIFO goes empty mid-stream: pops stop and the buffer drains. There are no spurious reads on an empty FIFO; `fifo_rd_en` never asserts while `fifo_empty` = 1.

## Timing
- Reset values: `m_valid` = 0, `m_data` = 0, `fifo_rd_en` = 0, `pop_count` = 0, `occ` = EMPTY, `inflight` = 0, skid = 0.
- Latency: `fifo_rd_en` high in cycle N → data captured at the end of N+1 → `m_valid` = 1 in N+2.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle after the 2-cycle fill.
- Consumer stall: at most 2 words are held (buffer + in-flight ≤ 2). No data is dropped or duplicated.
- Reset mid-operation: in-flight data is discarded and all state returns to reset values the cycle after `rst` is sampled high. `fifo_rd_en` is 0 during reset.
- Simultaneous fire and capture in OCC_ONE: occupancy stays ONE and the head takes the new word.

## Structure
- Shared package `fifo_rtl_pkg` holds:
  - The `occ_t` enum (OCC_EMPTY/OCC_ONE/OCC_TWO).
  - Default `DATA_WIDTH`/`CNT_WIDTH` localparams.
- The testbench package imports `fifo_rtl_pkg` for reference-model checks.
- One sub-module: `fifo_skid_buf`, the 2-entry head/skid register pair with its occupancy FSM.
  - The top level keeps the credit logic, `inflight`, and `pop_count`.

## Test plan
- Reset, then FIFO preloaded with 0x01..0x08, `rd_enable` = 1, `m_ready` = 1 → `m_data` 0x01..0x08 on 8 consecutive cycles starting 2 cycles after the first `fifo_rd_en`; `pop_count` = 8.
- Same preload with `m_ready` low for 5 cycles after the first `m_valid` → exactly 2 pops issued, `m_data` = 0x01 held stable. After release, 0x01..0x08 arrive in order with no loss.
- `m_ready` toggling 1/0 every cycle over 16 words → all 16 delivered in order; `fifo_rd_en` never asserts with `fifo_empty` = 1.
- `rd_enable` dropped 1 cycle after a pop → the in-flight word is still delivered; no further pops; `m_valid` falls once the buffer drains.
- `rst` asserted with `occ` = TWO and `inflight` = 1 → the next cycle `m_valid` = 0, `pop_count` = 0, `fifo_rd_en` = 0.
- `CNT_WIDTH` = 4 with 17 words delivered → `pop_count` = 1, showing wrap.
